rv32i_multicycle_ctrl: RTL
==========================

Name: rv32i_multicycle_ctrl

Overview:
Multicycle control FSM for the RV32I datapath. It sequences fetch, decode, execute, memory and writeback over one shared memory port. It drives the immediate-format select into the immediate generator, plus ALU, PC, IR, register-file and memory controls. It handles LOAD, STORE, BRANCH, OP and OP-IMM, and traps on anything else or on a memory timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for mem_ready per access; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
instr  in  32  current instruction from the datapath IR (valid from DECODE onward)
mem_ready  in  1  memory completes the current access this cycle
alu_zero  in  1  ALU result == 0
alu_lt  in  1  signed rs1 < rs2
alu_ltu  in  1  unsigned rs1 < rs2
mem_req  out  1  memory access request
mem_we  out  1  1 = store, 0 = read
iord  out  1  memory address source: 0 = PC, 1 = ALUOut
ir_write  out  1  load IR from memory read data
pc_write  out  1  update PC
pc_src  out  1  0 = PC+4, 1 = ALUOut
alu_out_write  out  1  latch ALU result into ALUOut
imm_sel  out  2  0 = I, 1 = S, 2 = B
alu_src_a  out  1  0 = old PC, 1 = rs1
alu_src_b  out  1  0 = rs2, 1 = imm
alu_op  out  4  ALU operation code (package constants)
reg_write  out  1  register-file write enable
wb_sel  out  1  0 = ALUOut, 1 = memory data
trap  out  1  sticky trap flag
trap_cause  out  2  0 = none, 1 = illegal instruction, 2 = memory timeout
state  out  3  current state, for debug

Behaviour:
- Reset:
  - state = FETCH; all write enables, mem_req and trap = 0; trap_cause = 0; timeout counter = 0.
  - Asynchronous reset mid-access drops mem_req immediately; no write is issued that cycle.
- Handshake:
  - mem_req, mem_we and iord stay stable until a rising edge samples mem_ready = 1.
  - mem_ready while mem_req = 0 is ignored.
- Timeout counter:
  - Clears on entry to FETCH and MEM; increments each waiting cycle.
  - When it reaches MEM_TIMEOUT (if nonzero) without mem_ready: go to TRAP, cause 2.
- FETCH: mem_req = 1, iord = 0. In the cycle mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
- DECODE (1 cycle):
  - imm_sel from opcode.
  - alu_src_a = 0, alu_src_b = 1, alu_op = ADD, alu_out_write = 1 (computes the branch target).
  - Illegal instruction goes to TRAP, cause 1. Illegal means any of:
    - opcode outside the five supported;
    - BRANCH funct3 010/011;
    - LOAD funct3 011/110/111;
    - STORE funct3 > 010;
    - OP funct7 not 0000000, or 0100000 with funct3 other than 000/101;
    - OP-IMM shift with a bad funct7.
  - Otherwise go to EXEC.
- EXEC:
  - LOAD/STORE: alu_src_a = 1, alu_src_b = 1, ADD, alu_out_write = 1, go to MEM.
  - OP: alu_src_b = 0, alu_op from funct3/funct7[5], alu_out_write = 1, go to WB.
  - OP-IMM: alu_src_b = 1; funct7[5] is used only for funct3 101 (SRAI); go to WB.
  - BRANCH:
    - alu_src_a = 1, alu_src_b = 0, SUB; the ALUOut target is not overwritten.
    - Taken conditions: BEQ zero, BNE !zero, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu.
    - If taken: pc_write = 1, pc_src = 1. Either way go to FETCH.
- MEM:
  - mem_req = 1, iord = 1, mem_we = 1 for STORE.
  - On mem_ready: STORE goes to FETCH, LOAD goes to WB.
- WB: reg_write = 1; wb_sel = 1 for LOAD, 0 otherwise; go to FETCH.
- TRAP: all enables 0, mem_req = 0; stays in TRAP until reset; trap and trap_cause hold.
- Latency with zero-wait memory:
  - branch 3 cycles; store 4; ALU ops 4; load 5.
  - Each wait cycle adds 1.
- Simultaneous events: mem_ready in the same cycle the counter hits MEM_TIMEOUT counts as success.

Decomposition:
- Package rv32_ctrl_pkg:
  - opcode constants (LOAD 0000011, STORE 0100011, BRANCH 1100011, OP 0110011, OP-IMM 0010011);
  - state enum FETCH / DECODE / EXEC / MEM / WB / TRAP;
  - alu_op codes ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9;
  - imm_sel and trap_cause codes.
- One sub-module, alu_op_decoder:
  - inputs: opcode, funct3, funct7;
  - outputs: alu_op, illegal.

Test Plan:
- Reset, then lw x5,8(x2) (0x00812283), mem_ready high every cycle -> states F, D, E, M, W; imm_sel = 0; MEM has iord = 1, mem_we = 0; WB has reg_write = 1, wb_sel = 1; 5 cycles total.
- sw x5,12(x2) (0x00512623) with mem_ready delayed 3 cycles in MEM -> mem_req and mem_we held high 4 cycles; imm_sel = 1; back to FETCH; reg_write never asserted.
- beq x1,x2,+8 (0x00208463):
  - alu_zero = 1 -> EXEC has pc_write = 1, pc_src = 1, then FETCH;
  - alu_zero = 0 -> no pc_write in EXEC;
  - imm_sel = 2 in DECODE.
- sub x3,x1,x2 (0x402081B3) -> EXEC alu_op = SUB, alu_src_b = 0; WB has reg_write = 1, wb_sel = 0.
- instr 0xFFFFFFFF -> TRAP after DECODE, trap = 1, cause = 1; no writes for 10 further cycles; rst_n pulse -> FETCH, trap = 0.
- FETCH with mem_ready held 0 and MEM_TIMEOUT = 16 -> TRAP cause 2 after 16 cycles; repeat with mem_ready arriving on cycle 16 -> DECODE.

Source files
------------

// File: rtl/rv32i_multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, FSM states,
// ALU operation codes, immediate-format selects and trap causes.
package rv32_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // Immediate format implied by the opcode; I-format covers LOAD and OP-IMM.
  function automatic logic [1:0] imm_sel_of(input logic [6:0] opcode);
    case (opcode)
      OPC_STORE:  return IMM_S;
      OPC_BRANCH: return IMM_B;
      default:    return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl_alu_op_decoder.sv
// Maps opcode/funct3/funct7 to an ALU operation and flags encodings the
// controller does not support.
module alu_op_decoder
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_op_o,
  output logic       illegal_o
);

  logic [3:0] arith_op_s;

  // funct3 selects the operation; funct7[5] only distinguishes SRA from SRL here.
  always_comb begin
    case (funct3_i)
      3'b000:  arith_op_s = ALU_ADD;
      3'b001:  arith_op_s = ALU_SLL;
      3'b010:  arith_op_s = ALU_SLT;
      3'b011:  arith_op_s = ALU_SLTU;
      3'b100:  arith_op_s = ALU_XOR;
      3'b101:  arith_op_s = funct7_i[5] ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op_s = ALU_OR;
      3'b111:  arith_op_s = ALU_AND;
      default: arith_op_s = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_LOAD:   illegal_o = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
      OPC_STORE:  illegal_o = (funct3_i > 3'b010);
      OPC_BRANCH: begin
        alu_op_o  = ALU_SUB;
        illegal_o = (funct3_i[2:1] == 2'b01);
      end
      OPC_OP: begin
        alu_op_o  = ((funct3_i == 3'b000) && funct7_i[5]) ? ALU_SUB : arith_op_s;
        illegal_o = !((funct7_i == 7'b0000000) ||
                      ((funct7_i == 7'b0100000) &&
                       ((funct3_i == 3'b000) || (funct3_i == 3'b101))));
      end
      OPC_OP_IMM: begin
        alu_op_o = arith_op_s;
        if (funct3_i == 3'b001) begin
          illegal_o = (funct7_i != 7'b0000000);
        end else if (funct3_i == 3'b101) begin
          illegal_o = (funct7_i != 7'b0000000) && (funct7_i != 7'b0100000);
        end else begin
          illegal_o = 1'b0;
        end
      end
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a single shared memory port and traps on illegal opcodes or stalled memory.
module rv32i_multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_out_write,
  output logic [1:0]  imm_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic [3:0] dec_op_s;
  logic       illegal_s;
  logic       taken_s;
  logic       timeout_s;
  logic       unused_instr_s;

  assign opcode_s       = instr[6:0];
  assign funct3_s       = instr[14:12];
  assign funct7_s       = instr[31:25];
  assign unused_instr_s = ^{instr[24:15], instr[11:7]};

  // Counter holds the waits already spent; this wait is the one that reaches the limit.
  assign timeout_s = (MEM_TIMEOUT != 32'd0) && ((cnt_q + 32'd1) == MEM_TIMEOUT);

  alu_op_decoder u_dec (
    .opcode_i  (opcode_s),
    .funct3_i  (funct3_s),
    .funct7_i  (funct7_s),
    .alu_op_o  (dec_op_s),
    .illegal_o (illegal_s)
  );

  // Branch condition from funct3 and the ALU compare flags.
  always_comb begin
    case (funct3_s)
      3'b000:  taken_s = alu_zero;
      3'b001:  taken_s = !alu_zero;
      3'b100:  taken_s = alu_lt;
      3'b101:  taken_s = !alu_lt;
      3'b110:  taken_s = alu_ltu;
      3'b111:  taken_s = !alu_ltu;
      default: taken_s = 1'b0;
    endcase
  end

  // Next state and control outputs; reset gates every enable so an access drops at once.
  always_comb begin
    state_d       = state_q;
    cnt_d         = 32'd0;
    cause_d       = cause_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_out_write = 1'b0;
    imm_sel       = imm_sel_of(opcode_s);
    alu_src_a     = 1'b0;
    alu_src_b     = 1'b0;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    wb_sel        = 1'b0;
    if (!rst_n) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (timeout_s) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_DECODE: begin
          alu_src_b     = 1'b1;
          alu_out_write = 1'b1;
          if (illegal_s) begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = dec_op_s;
          if (opcode_s == OPC_BRANCH) begin
            // ALUOut keeps the target computed in DECODE.
            pc_write = taken_s;
            pc_src   = taken_s;
            state_d  = S_FETCH;
          end else if ((opcode_s == OPC_LOAD) || (opcode_s == OPC_STORE)) begin
            alu_src_b     = 1'b1;
            alu_out_write = 1'b1;
            state_d       = S_MEM;
          end else begin
            alu_src_b     = (opcode_s == OPC_OP_IMM);
            alu_out_write = 1'b1;
            state_d       = S_WB;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (opcode_s == OPC_STORE);
          if (mem_ready) begin
            state_d = (opcode_s == OPC_STORE) ? S_FETCH : S_WB;
          end else if (timeout_s) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = (opcode_s == OPC_LOAD);
          state_d   = S_FETCH;
        end
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign state      = state_q;

  // State, wait counter and sticky trap cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= 32'd0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule
